// File: rtl/flash_seq.sv
// flash_seq: SPI flash transaction sequencer in front of the flash_io byte shifter.
// Ports: CLK/RSTn; START+CMD/ADDR/USEADR/LEN/WRDIR request; WDATA/WACK write feed;
//   RDATA/RVALID read data; BUSY/DONE status; CS_N/FEN/BWS/BDO/BRS/BDI to the shifter.
//   Optional macro FLASH_POLL_EN: write-type commands are followed by WIP polling.
module flash_seq #(
   parameter int SHIFT_CYC = 17,
   parameter int CS_SETUP  = 2,
   parameter int CS_HOLD   = 4
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        START,
   input  logic [7:0]  CMD,
   input  logic [23:0] ADDR,
   input  logic        USEADR,
   input  logic [8:0]  LEN,
   input  logic        WRDIR,
   input  logic [7:0]  WDATA,
   output logic        WACK,
   output logic [7:0]  RDATA,
   output logic        RVALID,
   output logic        BUSY,
   output logic        DONE,
   output logic        CS_N,
   output logic        FEN,
   output logic        BWS,
   output logic [7:0]  BDO,
   output logic        BRS,
   input  logic [7:0]  BDI
);

   localparam logic [7:0] SLOT_LAST  = 8'(SHIFT_CYC);
   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_CMD,
      S_A2,
      S_A1,
      S_A0,
      S_DATA,
      S_HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [8:0]  left_q, left_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [23:0] addr_q, addr_d;
   logic        useadr_q, useadr_d;
   logic        wrdir_q, wrdir_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        done_q, done_d;
`ifdef FLASH_POLL_EN
   logic        poll_q, poll_d;
   logic        wip_q, wip_d;
   logic        poll_go;
`endif

   logic   in_slot;
   logic   slot_end;
   state_t hdr_next;

   assign in_slot  = (state_q == S_CMD) || (state_q == S_A2) ||
                     (state_q == S_A1)  || (state_q == S_A0) ||
                     (state_q == S_DATA);
   assign slot_end = in_slot && (cnt_q == SLOT_LAST);
   // Header done: go to data if any bytes remain, else deselect.
   assign hdr_next = (left_q != 9'd0) ? S_DATA : S_HOLD;

`ifdef FLASH_POLL_EN
   // Write-type commands start polling; a poll repeats while WIP=1.
   assign poll_go = poll_q ? wip_q :
                    ((cmd_q == 8'h02) || (cmd_q == 8'hD8) ||
                     (cmd_q == 8'hC7));
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = 8'(cnt_q + 8'd1);
      left_d   = left_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      useadr_d = useadr_q;
      wrdir_d  = wrdir_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      done_d   = 1'b0;
`ifdef FLASH_POLL_EN
      poll_d   = poll_q;
      wip_d    = wip_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (START) begin
               cmd_d    = CMD;
               addr_d   = ADDR;
               useadr_d = USEADR;
               wrdir_d  = WRDIR;
               left_d   = (LEN > 9'd256) ? 9'd256 : LEN;
               state_d  = S_SETUP;
`ifdef FLASH_POLL_EN
               poll_d   = 1'b0;
`endif
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            if (slot_end) begin
               cnt_d   = 8'd0;
               state_d = useadr_q ? S_A2 : hdr_next;
            end
         end
         S_A2: begin
            if (slot_end) begin
               cnt_d   = 8'd0;
               state_d = S_A1;
            end
         end
         S_A1: begin
            if (slot_end) begin
               cnt_d   = 8'd0;
               state_d = S_A0;
            end
         end
         S_A0: begin
            if (slot_end) begin
               cnt_d   = 8'd0;
               state_d = hdr_next;
            end
         end
         S_DATA: begin
            if (slot_end) begin
               cnt_d  = 8'd0;
               left_d = left_q - 9'd1;
               if (left_q == 9'd1) state_d = S_HOLD;
               if (!wrdir_q) begin
`ifdef FLASH_POLL_EN
                  if (poll_q) begin
                     wip_d = BDI[0];
                  end else begin
                     rdata_d  = BDI;
                     rvalid_d = 1'b1;
                  end
`else
                  rdata_d  = BDI;
                  rvalid_d = 1'b1;
`endif
               end
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d = 8'd0;
`ifdef FLASH_POLL_EN
               if (poll_go) begin
                  state_d  = S_SETUP;
                  poll_d   = 1'b1;
                  cmd_d    = 8'h05;
                  useadr_d = 1'b0;
                  wrdir_d  = 1'b0;
                  left_d   = 9'd1;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  poll_d  = 1'b0;
               end
`else
               state_d = S_IDLE;
               done_d  = 1'b1;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      BUSY = (state_q != S_IDLE);
      FEN  = (state_q != S_IDLE);
      CS_N = !((state_q == S_SETUP) || in_slot);
      BWS  = in_slot && (cnt_q == 8'd0);
      BRS  = slot_end;
      BDO  = 8'h00;
      if (BWS) begin
         case (state_q)
            S_CMD:   BDO = cmd_q;
            S_A2:    BDO = addr_q[23:16];
            S_A1:    BDO = addr_q[15:8];
            S_A0:    BDO = addr_q[7:0];
            S_DATA:  BDO = wrdir_q ? WDATA : 8'hFF;
            default: BDO = 8'h00;
         endcase
      end
      WACK   = BWS && (state_q == S_DATA) && wrdir_q;
      RDATA  = rdata_q;
      RVALID = rvalid_q;
      DONE   = done_q;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         left_q   <= 9'd0;
         cmd_q    <= 8'h00;
         addr_q   <= 24'h0;
         useadr_q <= 1'b0;
         wrdir_q  <= 1'b0;
         rdata_q  <= 8'h00;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef FLASH_POLL_EN
         poll_q   <= 1'b0;
         wip_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         useadr_q <= useadr_d;
         wrdir_q  <= wrdir_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         done_q   <= done_d;
`ifdef FLASH_POLL_EN
         poll_q   <= poll_d;
         wip_q    <= wip_d;
`endif
      end
   end

endmodule
